mem_arb_ctrl: RTL and testbench
===============================

# mem_arb_ctrl

Multi-channel memory access controller that arbitrates between `NUM_CH` requesters and drives a single-port synchronous block RAM with byte-lane write enables and a configurable read latency. It sits between processing/DMA front-ends and the memory macro, replacing the single-requester read/write sequencer. It returns read data with a per-channel valid pulse.

## Interface
- `NUM_CH`, 2: number of requesting channels; minimum 2.
- `ADDR_W`, 10: address width in words.
- `DATA_W`, 32: data width; must be a multiple of 8. `BE_W = DATA_W/8` is derived.
- `RD_LAT`, 1: memory read latency in cycles; minimum 1, maximum 15.

Ports:
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `req_i`  in  `NUM_CH`  per-channel request; held high until `gnt_o`.
- `we_i`  in  `NUM_CH`×`BE_W`  per-channel byte write enables. Non-zero means a write; zero means a read.
- `addr_i`  in  `NUM_CH`×`ADDR_W`  per-channel word address.
- `wdata_i`  in  `NUM_CH`×`DATA_W`  per-channel write data.
- `gnt_o`  out  `NUM_CH`  one-hot, one-cycle grant pulse.
- `rvalid_o`  out  `NUM_CH`  one-hot, one-cycle read-data-valid pulse.
- `rdata_o`  out  `DATA_W`  read data, meaningful only while any `rvalid_o` bit is set.
- `ready_o`  out  1  high in IDLE; the controller can accept an arbitration.
- `mem_en_o`  out  1  memory enable.
- `mem_we_o`  out  `BE_W`  memory byte write enables.
- `mem_addr_o`  out  `ADDR_W`  memory address.
- `mem_wdata_o`  out  `DATA_W`  memory write data.
- `mem_rdata_i`  in  `DATA_W`  memory read data, valid `RD_LAT` cycles after the enabling edge.

## Operation
- States: IDLE, ACCESS, RD_WAIT, RD_RESP.
- **IDLE**
  - If any `req_i` bit is set, arbitrate and go to ACCESS.
  - On that edge, register the winner index, `addr_i`, `wdata_i` and `we_i` of the winner.
  - With no request, stay in IDLE.
- **ACCESS**
  - `mem_en_o`=1, `gnt_o[winner]`=1.
  - `mem_addr_o`/`mem_wdata_o` come from the registered values.
  - `mem_we_o` = registered `we` for a write; 0 for a read.
  - Write: next state is IDLE.
  - Read: if `RD_LAT`=1, next state is RD_RESP; otherwise RD_WAIT with the counter loaded to `RD_LAT`-2.
- **RD_WAIT**
  - `mem_en_o`=0.
  - Counter decrements each cycle; at 0, next state is RD_RESP.
- **RD_RESP**
  - `rvalid_o[winner]`=1 and `rdata_o` = `mem_rdata_i` (combinational passthrough).
  - Next state is IDLE.
- **Arbitration:** round-robin.
  - A pointer `rr_ptr` names the highest-priority channel. The search runs `rr_ptr`, `rr_ptr`+1, … modulo `NUM_CH`.
  - On a grant, `rr_ptr` becomes (winner+1) mod `NUM_CH`.
  - `rr_ptr` is unchanged when there is no grant.
- New requests arriving outside IDLE are not observed until the return to IDLE. Requesters hold their inputs stable.
- An illegal or unreached state encoding returns to IDLE.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `ready_o`=1, all other outputs 0, counter 0.
- Write: request sampled at edge t → ACCESS during cycle t+1 (grant and memory write) → IDLE at t+2. Throughput is one write per 2 cycles.
- Read: ACCESS in cycle t+1 → `rvalid_o` in cycle t+1+`RD_LAT` → IDLE at t+2+`RD_LAT`.
- `ready_o` = (state==IDLE), combinational from the state register.
- A request deasserted before its grant while in IDLE is simply not arbitrated. Behaviour is undefined if it is dropped after being registered; the access still completes.
- Asynchronous reset asserted mid-access:
  - Outputs clear immediately.
  - A pending read produces no `rvalid_o`.
  - `rr_ptr` returns to 0.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority; the lowest-indexed requesting channel always wins, and `rr_ptr` is not implemented.
  - Undefined (default): round-robin as described.

## Test plan
- **Reset:** hold `rst_ni`=0 for 3 cycles with `req_i`=all-ones. Required: `ready_o`=1, and `mem_en_o`, `gnt_o`, `rvalid_o` stay 0. After release, ch0 is granted first.
- **Byte write:** ch1 with `we`=4'b0101, addr 0x3A, data 0xDEADBEEF. Required: one cycle with `mem_en_o`=1, `mem_we_o`=4'b0101, `mem_addr_o`=0x3A, `gnt_o`=2'b10. `ready_o` returns to 1 on the next cycle.
- **Read latency:** `RD_LAT`=3, ch0 reads addr 0x10 with the memory model returning 0x12345678. Required: `rvalid_o`=2'b01 exactly 3 cycles after the ACCESS cycle, with `rdata_o`=0x12345678, and one pulse only.
- **Round-robin fairness:** both channels request continuously for 8 grants. Required: the grants alternate ch0, ch1, ch0, …. With `MEM_ARB_FIXED_PRIO_EN` defined, all 8 grants go to ch0.
- **Reset mid-read:** `RD_LAT`=4, assert `rst_ni`=0 during RD_WAIT. Required: no `rvalid_o`, immediate IDLE, and the next request is handled normally.

Source files
------------

// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl: arbitrates NUM_CH requesters onto one single-port synchronous
// block RAM with byte-lane write enables and a RD_LAT-cycle read latency.
//
// Ports:
//   clk_i, rst_ni      clock (rising edge), asynchronous active-low reset
//   req_i              per-channel request, held until gnt_o
//   we_i               per-channel byte enables (non-zero = write, zero = read)
//   addr_i, wdata_i    per-channel word address / write data
//   gnt_o              one-hot grant pulse (coincides with the memory access)
//   rvalid_o, rdata_o  one-hot read-valid pulse and read data
//   ready_o            controller idle and able to arbitrate
//   mem_*              memory macro interface
//
// Build option: define MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins, no round-robin pointer); default is round-robin.
module mem_arb_ctrl #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_CH-1:0]              req_i,
    input  logic [NUM_CH*(DATA_W/8)-1:0]   we_i,
    input  logic [NUM_CH*ADDR_W-1:0]       addr_i,
    input  logic [NUM_CH*DATA_W-1:0]       wdata_i,
    output logic [NUM_CH-1:0]              gnt_o,
    output logic [NUM_CH-1:0]              rvalid_o,
    output logic [DATA_W-1:0]              rdata_o,
    output logic                           ready_o,
    output logic                           mem_en_o,
    output logic [DATA_W/8-1:0]            mem_we_o,
    output logic [ADDR_W-1:0]              mem_addr_o,
    output logic [DATA_W-1:0]              mem_wdata_o,
    input  logic [DATA_W-1:0]              mem_rdata_i
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned CNT_W = 4;
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RD_WAIT = 2'd2,
        RD_RESP = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CH_W-1:0]     win_q, win_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     we_q, we_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_CH-1:0]   gnt_q, gnt_d;
    logic [NUM_CH-1:0]   rvalid_q, rvalid_d;
    logic                mem_en_q, mem_en_d;
    logic [BE_W-1:0]     mem_we_q, mem_we_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
`endif

    logic [BE_W-1:0]     ch_we    [NUM_CH];
    logic [ADDR_W-1:0]   ch_addr  [NUM_CH];
    logic [DATA_W-1:0]   ch_wdata [NUM_CH];

    logic                arb_found;
    logic [CH_W-1:0]     arb_win;
    logic [CH_W-1:0]     arb_cand;
    int unsigned         arb_start;

    // Unpack the flattened per-channel buses.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
        assign ch_we[c]    = we_i[c*BE_W +: BE_W];
        assign ch_addr[c]  = addr_i[c*ADDR_W +: ADDR_W];
        assign ch_wdata[c] = wdata_i[c*DATA_W +: DATA_W];
    end

    // Priority search starting at the highest-priority channel.
    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        arb_cand  = '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        arb_start = 0;
`else
        arb_start = 32'(rr_ptr_q);
`endif
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            arb_cand = CH_W'((arb_start + i) % NUM_CH);
            if (!arb_found && req_i[arb_cand]) begin
                arb_found = 1'b1;
                arb_win   = arb_cand;
            end
        end
    end

    // Next-state and next-output logic; outputs are registered alongside state.
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        cnt_d    = cnt_q;
        gnt_d    = '0;
        rvalid_d = '0;
        mem_en_d = 1'b0;
        mem_we_d = '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d        = ACCESS;
                    win_d          = arb_win;
                    addr_d         = ch_addr[arb_win];
                    wdata_d        = ch_wdata[arb_win];
                    we_d           = ch_we[arb_win];
                    gnt_d[arb_win] = 1'b1;
                    mem_en_d       = 1'b1;
                    mem_we_d       = ch_we[arb_win];
`ifndef MEM_ARB_FIXED_PRIO_EN
                    rr_ptr_d = (arb_win == LAST_CH) ? '0 : arb_win + CH_W'(1);
`endif
                end
            end
            ACCESS: begin
                if (we_q != '0) begin
                    state_d = IDLE;
                end else if (RD_LAT == 1) begin
                    state_d         = RD_RESP;
                    rvalid_d[win_q] = 1'b1;
                end else begin
                    state_d = RD_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    state_d         = RD_RESP;
                    rvalid_d[win_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RD_RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            win_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            mem_en_q <= 1'b0;
            mem_we_q <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            mem_en_q <= mem_en_d;
            mem_we_q <= mem_we_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    assign gnt_o       = gnt_q;
    assign rvalid_o    = rvalid_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign ready_o     = (state_q == IDLE);
    // Read data is a gated passthrough of the memory output.
    assign rdata_o     = (|rvalid_q) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Scoreboard bench for mem_arb_ctrl: stimulus pushes expected grants and read
// responses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_arb_ctrl;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned RD_LAT = 3;

    logic                      clk_i = 1'b0;
    logic                      rst_ni;
    logic [NUM_CH-1:0]         req;
    logic [BE_W-1:0]           t_we    [NUM_CH];
    logic [ADDR_W-1:0]         t_addr  [NUM_CH];
    logic [DATA_W-1:0]         t_wd    [NUM_CH];
    logic [NUM_CH*BE_W-1:0]    we_i;
    logic [NUM_CH*ADDR_W-1:0]  addr_i;
    logic [NUM_CH*DATA_W-1:0]  wdata_i;
    logic [NUM_CH-1:0]         gnt_o, rvalid_o;
    logic [DATA_W-1:0]         rdata_o;
    logic                      ready_o, mem_en_o;
    logic [BE_W-1:0]           mem_we_o;
    logic [ADDR_W-1:0]         mem_addr_o;
    logic [DATA_W-1:0]         mem_wdata_o, mem_rdata_i;

    assign we_i    = {t_we[1], t_we[0]};
    assign addr_i  = {t_addr[1], t_addr[0]};
    assign wdata_i = {t_wd[1], t_wd[0]};

    always #5 clk_i = ~clk_i;

    mem_arb_ctrl #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)
    ) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req), .we_i(we_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .ready_o(ready_o), .mem_en_o(mem_en_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i)
    );

    // Memory model: byte-lane writes, RD_LAT-stage read pipeline.
    logic [DATA_W-1:0] mem [1 << ADDR_W];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];
    bit                mem_loaded = 1'b0;

    always @(posedge clk_i) begin
        if (!mem_loaded) begin
            for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= '0;
            mem[10'h010] <= 32'h12345678;
            mem_loaded   <= 1'b1;
        end else if (mem_en_o && mem_we_o != '0) begin
            for (int b = 0; b < BE_W; b++)
                if (mem_we_o[b]) mem[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
        if (mem_en_o && mem_we_o == '0) rd_pipe[0] <= mem[mem_addr_o];
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rdata_i = rd_pipe[RD_LAT-1];

    typedef struct {
        int                ch;
        logic [BE_W-1:0]   we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } gexp_t;

    typedef struct {
        int                ch;
        logic [DATA_W-1:0] data;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int    lat_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    chk_ready = 1'b0;
    gexp_t mon_g;
    rexp_t mon_r;
    int    mon_lat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every grant and read response against the scoreboard.
    always @(negedge clk_i) begin
        cyc++;
        if (rst_ni) begin
            if (chk_ready) begin
                check("ready_after_done", 64'(ready_o), 64'd1);
                chk_ready = 1'b0;
            end
            check("mem_en_vs_gnt", 64'(mem_en_o), 64'(|gnt_o));
            if (|gnt_o) begin
                if (gq.size() == 0) begin
                    check("unexpected_gnt", 64'(gnt_o), 64'd0);
                end else begin
                    mon_g = gq.pop_front();
                    check("gnt", 64'(gnt_o), 64'(1 << mon_g.ch));
                    check("mem_we", 64'(mem_we_o), 64'(mon_g.we));
                    check("mem_addr", 64'(mem_addr_o), 64'(mon_g.addr));
                    check("ready_in_access", 64'(ready_o), 64'd0);
                    if (mon_g.we != '0) begin
                        check("mem_wdata", 64'(mem_wdata_o), 64'(mon_g.data));
                        chk_ready = 1'b1;
                    end else begin
                        lat_q.push_back(cyc + RD_LAT);
                    end
                end
            end
            if (|rvalid_o) begin
                if (rq.size() == 0 || lat_q.size() == 0) begin
                    check("unexpected_rvalid", 64'(rvalid_o), 64'd0);
                end else begin
                    mon_r   = rq.pop_front();
                    mon_lat = lat_q.pop_front();
                    check("rvalid", 64'(rvalid_o), 64'(1 << mon_r.ch));
                    check("rdata", 64'(rdata_o), 64'(mon_r.data));
                    check("rd_latency", 64'(cyc), 64'(mon_lat));
                    chk_ready = 1'b1;
                end
            end
        end
    end

    task automatic set_ch(input int ch, input logic [BE_W-1:0] we,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        t_we[ch]   = we;
        t_addr[ch] = a;
        t_wd[ch]   = d;
        req[ch]    = 1'b1;
    endtask

    task automatic push_g(input int ch, input logic [BE_W-1:0] we,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        gexp_t g;
        g.ch = ch; g.we = we; g.addr = a; g.data = d;
        gq.push_back(g);
    endtask

    task automatic push_r(input int ch, input logic [DATA_W-1:0] d);
        rexp_t r;
        r.ch = ch; r.data = d;
        rq.push_back(r);
    endtask

    task automatic wait_gnt(input int ch, input bit drop);
        int n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!gnt_o[ch] && n < 100);
        if (!gnt_o[ch]) check($sformatf("timeout_gnt_ch%0d", ch), 64'(gnt_o), 64'(1 << ch));
        if (drop) req[ch] = 1'b0;
    endtask

    task automatic wait_any_gnt();
        int n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (gnt_o == '0 && n < 100);
        if (gnt_o == '0) check("timeout_any_gnt", 64'(gnt_o), 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((rq.size() != 0 || !ready_o) && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 100) check("timeout_idle", 64'(rq.size()), 64'd0);
        @(negedge clk_i);
    endtask

    initial begin
        bit seen_rv;
        rst_ni = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            t_we[c] = '0; t_addr[c] = '0; t_wd[c] = '0;
        end
        req = '0;

        // Reset held with both channels requesting.
        set_ch(0, 4'hF, 10'h100, 32'h11111111);
        set_ch(1, 4'hF, 10'h101, 32'h22222222);
        repeat (3) begin
            @(negedge clk_i);
            check("reset_outputs", 64'({ready_o, mem_en_o, gnt_o, rvalid_o}), 64'b100000);
        end
        push_g(0, 4'hF, 10'h100, 32'h11111111);
        rst_ni = 1'b1;
        wait_gnt(0, 1'b1);
        req[1] = 1'b0;
        wait_idle();

        // Byte-lane write from ch1.
        set_ch(1, 4'b0101, 10'h03A, 32'hDEADBEEF);
        push_g(1, 4'b0101, 10'h03A, 32'hDEADBEEF);
        wait_gnt(1, 1'b1);
        wait_idle();

        // Read with latency RD_LAT from ch0.
        set_ch(0, 4'h0, 10'h010, 32'h0);
        push_g(0, 4'h0, 10'h010, 32'h0);
        push_r(0, 32'h12345678);
        wait_gnt(0, 1'b1);
        wait_idle();

        // Read back the partially written word: only lanes 0 and 2 updated.
        set_ch(1, 4'h0, 10'h03A, 32'h0);
        push_g(1, 4'h0, 10'h03A, 32'h0);
        push_r(1, 32'h00AD00EF);
        wait_gnt(1, 1'b1);
        wait_idle();

        // Both channels request continuously for 8 grants.
        set_ch(0, 4'hF, 10'h020, 32'hA0A0A0A0);
        set_ch(1, 4'h3, 10'h021, 32'hB1B1B1B1);
        for (int k = 0; k < 8; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            push_g(0, 4'hF, 10'h020, 32'hA0A0A0A0);
`else
            if (k % 2 == 0) push_g(0, 4'hF, 10'h020, 32'hA0A0A0A0);
            else            push_g(1, 4'h3, 10'h021, 32'hB1B1B1B1);
`endif
        end
        for (int k = 0; k < 8; k++) wait_any_gnt();
        req = '0;
        wait_idle();

        // Reset asserted while the read is waiting on memory latency.
        set_ch(0, 4'h0, 10'h010, 32'h0);
        push_g(0, 4'h0, 10'h010, 32'h0);
        push_r(0, 32'h12345678);
        wait_gnt(0, 1'b1);
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        rq.delete();
        lat_q.delete();
        chk_ready = 1'b0;
        #1;
        check("mid_read_reset_outputs", 64'({ready_o, mem_en_o, gnt_o, rvalid_o}), 64'b100000);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        seen_rv = 1'b0;
        repeat (6) begin
            @(negedge clk_i);
            if (rvalid_o != '0) seen_rv = 1'b1;
        end
        check("no_rvalid_after_reset", 64'(seen_rv), 64'd0);

        // Normal operation afterwards; pointer back at ch0.
        set_ch(0, 4'h0, 10'h03A, 32'h0);
        set_ch(1, 4'h0, 10'h010, 32'h0);
        push_g(0, 4'h0, 10'h03A, 32'h0);
        push_g(1, 4'h0, 10'h010, 32'h0);
        push_r(0, 32'h00AD00EF);
        push_r(1, 32'h12345678);
        wait_gnt(0, 1'b1);
        wait_gnt(1, 1'b1);
        wait_idle();
        repeat (4) @(negedge clk_i);
        check("scoreboard_drained", 64'(gq.size() + rq.size() + lat_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
